// File: rtl/sha256_round_sched.sv
// sha256_round_sched: iterative SHA-256 compression, one round per cycle.
// Define SHA256_SCHED_PERF_EN to add the busy-cycle counter port cyc_cnt.
module sha256_round_sched #(
  parameter int MAX_BLOCKS = 20,
  localparam int CW = $clog2(MAX_BLOCKS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic [511:0]   blk_data,
  input  logic           blk_last,
  output logic           digest_valid,
  input  logic           digest_ready,
  output logic [255:0]   digest,
  output logic           busy,
  output logic [CW-1:0]  blk_cnt,
  output logic           blk_err
`ifdef SHA256_SCHED_PERF_EN
  ,output logic [31:0]   cyc_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, ROUND, FINAL, OUT, NEXT
  } state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int n
  );
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       state, state_nx;
  logic [5:0]   rnd;
  logic         last;
  logic         hs;
  logic [31:0]  hv [8];
  logic [31:0]  wk [8];
  logic [31:0]  w  [16];
  logic [31:0]  t1, t2, w_new;
  logic [31:0]  ch, maj;

  assign blk_ready    = rst_n && (state == IDLE || state == NEXT);
  assign digest_valid = rst_n && (state == OUT);
  assign busy         = rst_n && (state != IDLE);
  assign hs           = blk_valid && blk_ready;

  assign digest = {hv[0], hv[1], hv[2], hv[3],
                   hv[4], hv[5], hv[6], hv[7]};

  assign ch    = (wk[4] & wk[5]) ^ (~wk[4] & wk[6]);
  assign maj   = (wk[0] & wk[1]) ^ (wk[0] & wk[2])
               ^ (wk[1] & wk[2]);
  assign t1    = wk[7] + ep1(wk[4]) + ch + K[rnd] + w[0];
  assign t2    = ep0(wk[0]) + maj;
  assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hs) state_nx = ROUND;
      ROUND: if (rnd == 6'd63) state_nx = FINAL;
      FINAL: state_nx = last ? OUT : NEXT;
      OUT:   if (digest_ready) state_nx = IDLE;
      NEXT:  if (hs) state_nx = ROUND;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd     <= '0;
      last    <= 1'b0;
      blk_cnt <= '0;
      blk_err <= 1'b0;
      for (int i = 0; i < 8; i++) hv[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          hv      <= IV;
          rnd     <= '0;
          blk_cnt <= CW'(1);
          last    <= blk_last;
        end
        ROUND: rnd <= rnd + 6'd1;
        FINAL: for (int i = 0; i < 8; i++)
          hv[i] <= hv[i] + wk[i];
        NEXT: if (hs) begin
          rnd  <= '0;
          last <= blk_last;
          if (blk_cnt != '1) blk_cnt <= blk_cnt + CW'(1);
          // overflow still processes the block, only flags it
          if (blk_cnt == CW'(MAX_BLOCKS) && !blk_last)
            blk_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      if (state == IDLE) wk <= IV;
      else               wk <= hv;
      for (int i = 0; i < 16; i++)
        w[i] <= blk_data[511 - 32*i -: 32];
    end else if (state == ROUND) begin
      wk[0] <= t1 + t2;
      wk[1] <= wk[0];
      wk[2] <= wk[1];
      wk[3] <= wk[2];
      wk[4] <= wk[3] + t1;
      wk[5] <= wk[4];
      wk[6] <= wk[5];
      wk[7] <= wk[6];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

`ifdef SHA256_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    cyc_cnt <= '0;
    else if (busy) cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sha256_round_sched.sv
// tb_sha256_round_sched: directed SHA-256 vectors against the
// iterative round scheduler.
module tb_sha256_round_sched;

  localparam int MAXB = 20;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_last = 1'b0;
  logic         digest_ready = 1'b1;
  logic [511:0] blk_data = '0;
  logic         blk_ready, digest_valid, busy, blk_err;
  logic [255:0] digest;
  logic [4:0]   blk_cnt;
`ifdef SHA256_SCHED_PERF_EN
  logic [31:0]  cyc_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sha256_round_sched #(.MAX_BLOCKS(MAXB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data(blk_data),
    .blk_last(blk_last),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .digest(digest),
    .busy(busy),
    .blk_cnt(blk_cnt),
    .blk_err(blk_err)
`ifdef SHA256_SCHED_PERF_EN
    ,.cyc_cnt(cyc_cnt)
`endif
  );

  task automatic chk(
    input string tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge of the first cycle after the handshake.
  task automatic send(input logic [511:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    while (!blk_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) chk("send_ready_timeout", 256'(blk_ready), 256'd1);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_dv(output int lat);
    lat = 1;
    while (!digest_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  logic bad;
  logic [255:0] cap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_blk_ready", 256'(blk_ready), 256'd0);
    chk("rst_digest_valid", 256'(digest_valid), 256'd0);
    chk("rst_digest", digest, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_blk_cnt", 256'(blk_cnt), 256'd0);
    chk("rst_blk_err", 256'(blk_err), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_blk_ready", 256'(blk_ready), 256'd1);

    send(ABC, 1'b1);
    wait_dv(lat);
    chk("abc_latency", 256'(lat), 256'd66);
    chk("abc_digest", digest, ABC_D);
    chk("abc_blk_cnt", 256'(blk_cnt), 256'd1);
    @(negedge clk);
    chk("abc_back_idle", 256'(busy), 256'd0);
`ifdef SHA256_SCHED_PERF_EN
    chk("abc_cyc_cnt", 256'(cyc_cnt), 256'd66);
`endif

    send(EMPTY, 1'b1);
    wait_dv(lat);
    chk("empty_latency", 256'(lat), 256'd66);
    chk("empty_digest", digest, EMPTY_D);
    @(negedge clk);

    send(TWO1, 1'b0);
    bad = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (blk_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("two_ready_in_round", 256'(bad), 256'd0);
    @(negedge clk);
    chk("two_ready_t66", 256'(blk_ready), 256'd1);
    send(TWO2, 1'b1);
    wait_dv(lat);
    chk("two_latency", 256'(lat), 256'd66);
    chk("two_digest", digest, TWO_D);
    chk("two_blk_cnt", 256'(blk_cnt), 256'd2);
    @(negedge clk);

    digest_ready = 1'b0;
    send(ABC, 1'b1);
    wait_dv(lat);
    cap = digest;
    blk_valid = 1'b1;
    blk_data = EMPTY;
    blk_last = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digest !== cap || digest_valid !== 1'b1 || blk_ready !== 1'b0)
        bad = 1'b1;
    end
    chk("bp_stable", 256'(bad), 256'd0);
    chk("bp_digest", digest, ABC_D);
    blk_valid = 1'b0;
    digest_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", 256'(busy), 256'd0);
    chk("bp_idle_ready", 256'(blk_ready), 256'd1);
    chk("bp_cnt_held", 256'(blk_cnt), 256'd1);

    send(TWO1, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_blk_ready", 256'(blk_ready), 256'd0);
    chk("mid_rst_digest_valid", 256'(digest_valid), 256'd0);
    chk("mid_rst_digest", digest, 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_blk_cnt", 256'(blk_cnt), 256'd0);
    chk("mid_rst_blk_err", 256'(blk_err), 256'd0);
    rst_n = 1'b1;
    send(ABC, 1'b1);
    wait_dv(lat);
    chk("mid_abc_latency", 256'(lat), 256'd66);
    chk("mid_abc_digest", digest, ABC_D);
    @(negedge clk);

    for (int b = 1; b <= MAXB + 1; b++) begin
      send(EMPTY, 1'b0);
      if (b == MAXB) begin
        chk("ovf_err_at_20", 256'(blk_err), 256'd0);
        chk("ovf_cnt_20", 256'(blk_cnt), 256'd20);
      end
    end
    chk("ovf_err_at_21", 256'(blk_err), 256'd1);
    chk("ovf_cnt_21", 256'(blk_cnt), 256'd21);
    repeat (70) @(negedge clk);
    chk("ovf_err_sticky", 256'(blk_err), 256'd1);
    chk("ovf_wait_next", 256'(blk_ready), 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
